// File: rtl/hls_uint16_to_fp17_arb.sv
// Round-robin share of one uint16->fp17 core among NREQ requesters, with an in-order tag FIFO routing results back.
// Zero added latency on issue and return; a stalled result blocks all returns, and issue stops at TAG_DEPTH in flight.

module hls_uint16_to_fp17_arb_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge nvdla_core_clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
endmodule

module hls_uint16_to_fp17_arb #(
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rstn,
  input  logic [NREQ-1:0]            cfg_req_en,
  input  logic [NREQ-1:0]            req_vld,
  output logic [NREQ-1:0]            req_rdy,
  input  logic [16*NREQ-1:0]         req_pd,
  output logic                       core_i_vld,
  input  logic                       core_i_rdy,
  output logic [15:0]                core_i_pd,
  input  logic                       core_o_vld,
  output logic                       core_o_rdy,
  input  logic [16:0]                core_o_pd,
  output logic [NREQ-1:0]            rsp_vld,
  input  logic [NREQ-1:0]            rsp_rdy,
  output logic [16:0]                rsp_pd,
  output logic [$clog2(TAG_DEPTH):0] outstanding,
  output logic                       err_orphan
);
  localparam int TW = $clog2(NREQ);

  logic [NREQ-1:0] elig;
  logic [TW-1:0]   rr_ptr;
  logic [TW-1:0]   grant;
  logic [TW-1:0]   head;
  logic            any_elig;
  logic            tag_full;
  logic            tag_empty;
  logic            issue;
  logic            ret;
  logic            head_rdy;

  assign elig = req_vld & cfg_req_en;

  // Scan from farthest to nearest so the last hit is the first eligible at or after rr_ptr.
  always_comb begin
    logic [TW:0] sum;
    grant    = rr_ptr;
    any_elig = 1'b0;
    sum      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (TW+1)'(k);
      if (sum >= (TW+1)'(NREQ)) sum = sum - (TW+1)'(NREQ);
      if (elig[sum[TW-1:0]]) begin
        grant    = sum[TW-1:0];
        any_elig = 1'b1;
      end
    end
  end

  // Reset gating keeps the combinational valid low while the tag FIFO is being cleared.
  assign core_i_vld = nvdla_core_rstn & any_elig & ~tag_full;
  assign issue      = core_i_vld & core_i_rdy;

  always_comb begin
    core_i_pd = '0;
    req_rdy   = '0;
    rsp_vld   = '0;
    head_rdy  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == TW'(i)) begin
        core_i_pd  = req_pd[16*i +: 16];
        req_rdy[i] = issue;
      end
      if (head == TW'(i)) begin
        rsp_vld[i] = core_o_vld & ~tag_empty;
        head_rdy   = rsp_rdy[i];
      end
    end
  end

  assign core_o_rdy = head_rdy & ~tag_empty;
  assign ret        = core_o_vld & core_o_rdy;
  assign rsp_pd     = core_o_pd;

  hls_uint16_to_fp17_arb_fifo #(
    .WIDTH (TW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .push            (issue),
    .push_dat        (grant),
    .pop             (ret),
    .head_dat        (head),
    .empty           (tag_empty),
    .full            (tag_full),
    .count           (outstanding)
  );

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rr_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (issue) rr_ptr <= (grant == TW'(NREQ - 1)) ? '0 : grant + TW'(1);
      if (core_o_vld && tag_empty) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hls_uint16_to_fp17_arb.sv
// Bench for hls_uint16_to_fp17_arb: a queue-based core stand-in with configurable latency,
// a spec-level round-robin/tag model, a hand-derived grant table and directed corner sequences.
`timescale 1ns/1ps
module tb_hls_uint16_to_fp17_arb;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  cfg_req_en, req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [63:0] req_pd;
  logic        core_i_vld, core_i_rdy, core_o_vld, core_o_rdy;
  logic [15:0] core_i_pd;
  logic [16:0] core_o_pd, rsp_pd;
  logic [3:0]  outstanding;
  logic        err_orphan;

  always #5 clk = ~clk;

  hls_uint16_to_fp17_arb #(.NREQ(NREQ), .TAG_DEPTH(DEPTH)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .cfg_req_en      (cfg_req_en),
    .req_vld         (req_vld),
    .req_rdy         (req_rdy),
    .req_pd          (req_pd),
    .core_i_vld      (core_i_vld),
    .core_i_rdy      (core_i_rdy),
    .core_i_pd       (core_i_pd),
    .core_o_vld      (core_o_vld),
    .core_o_rdy      (core_o_rdy),
    .core_o_pd       (core_o_pd),
    .rsp_vld         (rsp_vld),
    .rsp_rdy         (rsp_rdy),
    .rsp_pd          (rsp_pd),
    .outstanding     (outstanding),
    .err_orphan      (err_orphan)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 3;
  bit hold = 0;
  bit force_o = 0;

  // Reference model state
  typedef struct { logic [15:0] pd; int due; } core_e_t;
  int          rr;
  int          tags[$];
  core_e_t     coreq[$];
  logic [16:0] expq[NREQ][$];
  bit          err_m;

  // Observations from the last cycle()
  logic [3:0]  s_rdy, s_rsp, s_out;
  logic        s_iv, s_ordy, s_err;
  logic [16:0] s_pd;
  int          acc_cnt[NREQ];
  int          max_out;

  typedef struct {
    logic [3:0] en;
    logic [3:0] vld;
    logic       irdy;
    logic       exp_iv;
    logic [3:0] exp_rdy;
    int         exp_out;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [16:0] conv(logic [15:0] x);
    return {x ^ 16'hA5C3, x[0]};
  endfunction

  function automatic int pick(int start, logic [3:0] el);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (start + k) % NREQ;
      if (el[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    tags.delete();
    coreq.delete();
    for (int i = 0; i < NREQ; i++) expq[i].delete();
    rr = 0;
    err_m = 0;
  endtask

  // One clock: inputs already set by the caller at a negedge; returns at the next negedge.
  task automatic cycle();
    int          g;
    logic [3:0]  el, exp_rsp;
    bit          exp_iv, exp_ordy, orph;
    logic [15:0] gpd;
    core_e_t     e;
    gpd = '0;
    if (force_o) begin
      core_o_vld = 1'b1; core_o_pd = 17'h1ABCD;
    end else if (!hold && coreq.size() > 0 && cyc >= coreq[0].due) begin
      core_o_vld = 1'b1; core_o_pd = conv(coreq[0].pd);
    end else begin
      core_o_vld = 1'b0; core_o_pd = '0;
    end
    #1;
    s_iv = core_i_vld; s_rdy = req_rdy; s_rsp = rsp_vld; s_out = outstanding;
    s_ordy = core_o_rdy; s_err = err_orphan; s_pd = rsp_pd;
    for (int i = 0; i < NREQ; i++) if (req_rdy[i] === 1'b1) acc_cnt[i]++;
    if (int'(outstanding) > max_out) max_out = int'(outstanding);

    el = req_vld & cfg_req_en;
    g = pick(rr, el);
    exp_iv = rstn && (g >= 0) && (tags.size() < DEPTH);
    chk("core_i_vld", core_i_vld, exp_iv);
    chk("req_rdy", req_rdy, (exp_iv && core_i_rdy) ? (4'b0001 << g) : 4'b0000);
    if (exp_iv) begin
      gpd = req_pd[16*g +: 16];
      chk("core_i_pd", core_i_pd, gpd);
    end
    exp_ordy = (tags.size() > 0) && rsp_rdy[tags[0]];
    exp_rsp  = (core_o_vld && tags.size() > 0) ? (4'b0001 << tags[0]) : 4'b0000;
    chk("rsp_vld", rsp_vld, exp_rsp);
    chk("core_o_rdy", core_o_rdy, exp_ordy);
    chk("outstanding", outstanding, tags.size());
    chk("err_orphan", err_orphan, err_m);
    if (exp_rsp != 0 && expq[tags[0]].size() > 0) chk("rsp_pd", rsp_pd, expq[tags[0]][0]);
    orph = rstn && core_o_vld && (tags.size() == 0);

    @(posedge clk);
    cyc++;
    if (core_o_vld && exp_ordy) begin
      void'(expq[tags[0]].pop_front());
      void'(tags.pop_front());
      void'(coreq.pop_front());
    end
    if (exp_iv && core_i_rdy) begin
      tags.push_back(g);
      rr = (g + 1) % NREQ;
      e.pd = gpd; e.due = cyc + lat - 1;
      coreq.push_back(e);
      expq[g].push_back(conv(gpd));
    end
    if (orph) err_m = 1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    hold = 0; force_o = 0;
    model_clear();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    req_vld = '0; hold = 0; force_o = 0; rsp_rdy = '1;
    while (tags.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    chk({name, "_drain_bound"}, (n < 200), 1);
    cycle();
    chk({name, "_drained"}, s_out, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ops[3];
    int          idx, k, offered, ord_bad, total;
    int          drain_seq[$];
    int          exp_seq[8];

    cfg_req_en = 4'hF; req_vld = 4'hF; core_i_rdy = 1'b1; rsp_rdy = 4'hF;
    req_pd = 64'h4444_3333_2222_1111;
    core_o_vld = 1'b0; core_o_pd = '0;
    model_clear();
    max_out = 0;
    for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;

    // Reset state: requests pending but nothing may be granted
    @(negedge clk);
    cycle();
    chk("rst_core_i_vld", s_iv, 0);
    chk("rst_req_rdy", s_rdy, 0);
    chk("rst_outstanding", s_out, 0);
    chk("rst_err", s_err, 0);
    apply_reset();

    // Hand-derived grant table, results held back in the core
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'b0001, 0};
    tbl[1]  = '{4'hF, 4'h1, 1'b1, 1'b1, 4'b0001, 1};
    tbl[2]  = '{4'hF, 4'h8, 1'b0, 1'b1, 4'b0000, 2};
    tbl[3]  = '{4'hF, 4'h9, 1'b1, 1'b1, 4'b1000, 2};
    tbl[4]  = '{4'hA, 4'hF, 1'b1, 1'b1, 4'b0010, 3};
    tbl[5]  = '{4'hA, 4'hF, 1'b1, 1'b1, 4'b1000, 4};
    tbl[6]  = '{4'h0, 4'hF, 1'b1, 1'b0, 4'b0000, 5};
    tbl[7]  = '{4'hF, 4'h6, 1'b1, 1'b1, 4'b0010, 5};
    tbl[8]  = '{4'hF, 4'h6, 1'b1, 1'b1, 4'b0100, 6};
    tbl[9]  = '{4'hF, 4'h5, 1'b1, 1'b1, 4'b0001, 7};
    tbl[10] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'b0000, 8};
    hold = 1; lat = 1;
    for (int i = 0; i < 11; i++) begin
      cfg_req_en = tbl[i].en; req_vld = tbl[i].vld; core_i_rdy = tbl[i].irdy;
      req_pd = {16'h4000 + 16'(i), 16'h3000 + 16'(i), 16'h2000 + 16'(i), 16'h1000 + 16'(i)};
      cycle();
      chk($sformatf("tbl%0d_iv", i), s_iv, tbl[i].exp_iv);
      chk($sformatf("tbl%0d_rdy", i), s_rdy, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_out", i), s_out, tbl[i].exp_out);
    end
    // Tags pushed in order 0,0,3,1,3,1,2,0 must come back in that order
    exp_seq = '{1, 1, 8, 2, 8, 2, 4, 1};
    hold = 0; req_vld = '0; rsp_rdy = '1; core_i_rdy = 1'b1;
    for (int n = 0; n < 30 && drain_seq.size() < 8; n++) begin
      cycle();
      if (s_rsp != 0) drain_seq.push_back(int'(s_rsp));
    end
    chk("tbl_drain_count", drain_seq.size(), 8);
    for (int i = 0; i < 8 && i < drain_seq.size(); i++)
      chk($sformatf("tbl_drain%0d", i), drain_seq[i], exp_seq[i]);
    drain("tbl");

    // Single requester, three operands, latency 3
    apply_reset();
    ops = '{16'h0000, 16'h0001, 16'hFFFF};
    lat = 3; cfg_req_en = 4'hF; rsp_rdy = 4'hF; core_i_rdy = 1'b1; max_out = 0;
    idx = 0; k = 0;
    for (int n = 0; n < 30; n++) begin
      req_vld = (idx < 3) ? 4'b0001 : 4'b0000;
      req_pd = {48'h0, (idx < 3) ? ops[idx] : 16'h0};
      cycle();
      if (s_rdy[0]) idx++;
      if (s_rsp[0] && k < 3) begin
        chk($sformatf("single_pd%0d", k), s_pd, conv(ops[k]));
        k++;
      end
      if (s_rsp[3:1] != 0) chk("single_other_rsp", s_rsp, 4'b0001);
    end
    chk("single_results", k, 3);
    chk("single_peak", max_out, 3);
    chk("single_final_out", s_out, 0);

    // Fairness: all four always valid
    apply_reset();
    lat = 3; cfg_req_en = 4'hF; req_vld = 4'hF; rsp_rdy = 4'hF; core_i_rdy = 1'b1;
    total = 0; ord_bad = 0;
    for (int n = 0; n < 300 && total < 100; n++) begin
      req_pd = {$urandom, $urandom};
      cycle();
      if (s_rdy != 0) begin
        if (s_rdy != (4'b0001 << (total % 4))) ord_bad++;
        total++;
      end
    end
    chk("fair_total", total, 100);
    chk("fair_order", ord_bad, 0);
    for (int i = 0; i < NREQ; i++) chk($sformatf("fair_cnt%0d", i), acc_cnt[i], 25);
    drain("fair");

    // Mask 1010
    apply_reset();
    cfg_req_en = 4'b1010; req_vld = 4'hF; total = 0;
    for (int n = 0; n < 100 && total < 20; n++) begin
      req_pd = {$urandom, $urandom};
      cycle();
      if (s_rdy != 0) total++;
    end
    chk("mask_cnt0", acc_cnt[0], 0);
    chk("mask_cnt1", acc_cnt[1], 10);
    chk("mask_cnt2", acc_cnt[2], 0);
    chk("mask_cnt3", acc_cnt[3], 10);
    drain("mask");

    // Full: results blocked by rsp_rdy, ten operands offered by requester 0
    apply_reset();
    lat = 2; cfg_req_en = 4'hF; rsp_rdy = 4'h0; offered = 0;
    for (int n = 0; n < 12; n++) begin
      req_vld = 4'b0001; req_pd = {48'h0, 16'h0100 + 16'(offered)};
      cycle();
      if (s_rdy[0]) offered++;
    end
    chk("full_accepted", offered, 8);
    chk("full_iv", s_iv, 0);
    chk("full_out", s_out, 8);
    // Release: the full cycle only pops, then push and pop overlap
    rsp_rdy = 4'hF; req_pd = {48'h0, 16'h0100 + 16'(offered)};
    cycle();
    if (s_rdy[0]) offered++;
    chk("rel_iv", s_iv, 0);
    chk("rel_pop", s_ordy, 1);
    chk("rel_out", s_out, 8);
    req_pd = {48'h0, 16'h0100 + 16'(offered)};
    cycle();
    if (s_rdy[0]) offered++;
    chk("rel2_push", s_rdy, 4'b0001);
    chk("rel2_pop", s_ordy, 1);
    chk("rel2_out", s_out, 7);
    req_pd = {48'h0, 16'h0100 + 16'(offered)};
    cycle();
    if (s_rdy[0]) offered++;
    chk("rel3_out", s_out, 7);
    chk("full_offered", offered, 10);
    drain("full");

    // Orphan result with nothing issued
    apply_reset();
    req_vld = '0; force_o = 1;
    cycle();
    chk("orph_ordy", s_ordy, 0);
    chk("orph_err_same", s_err, 0);
    force_o = 0;
    cycle();
    chk("orph_err_next", s_err, 1);
    repeat (5) cycle();
    chk("orph_err_sticky", s_err, 1);
    apply_reset();
    cycle();
    chk("orph_err_cleared", s_err, 0);

    // Reset with five in flight
    lat = 2; cfg_req_en = 4'hF; req_vld = 4'hF; rsp_rdy = 4'h0;
    repeat (5) cycle();
    req_vld = 4'h0;
    cycle();
    chk("mid_out_before", s_out, 5);
    req_vld = 4'hF; rsp_rdy = 4'hF; core_o_vld = 1'b1;
    rstn = 1'b0;
    #1;
    chk("mid_out_async", outstanding, 0);
    chk("mid_rsp_async", rsp_vld, 0);
    chk("mid_iv_async", core_i_vld, 0);
    chk("mid_rdy_async", req_rdy, 0);
    chk("mid_ordy_async", core_o_rdy, 0);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    cycle();
    chk("mid_first_grant", s_rdy, 4'b0001);
    drain("mid");

    // Randomized traffic against the model
    apply_reset();
    for (int blk = 0; blk < 6; blk++) begin
      lat = int'($urandom_range(1, 6));
      for (int n = 0; n < 250; n++) begin
        cfg_req_en = 4'($urandom);
        req_vld = 4'($urandom);
        req_pd = {$urandom, $urandom};
        core_i_rdy = ($urandom_range(0, 3) != 0);
        rsp_rdy = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
        cycle();
      end
    end
    core_i_rdy = 1'b1;
    drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
